// File: rtl/uc_mem_responder_if.sv
// Bundles the pipeline-side request, data-memory handshake and writeback signals of uc_mem_responder.
interface uc_mem_responder_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          MR_IN;
  logic          MW_IN;
  logic [5:0]    SelC_in;
  logic [6:0]    Type_in;
  logic [AW-1:0] ADDR_in;
  logic [DW-1:0] WDATA_in;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_ACK;
  logic          HOLD;
  logic          WB_EN;
  logic [5:0]    WB_SEL;
  logic [6:0]    WB_TYPE;
  logic [DW-1:0] WB_DATA;
  logic          ERR;

  // Responder side: drives the memory request, stall and writeback.
  modport master (
    input  MR_IN, MW_IN, SelC_in, Type_in, ADDR_in, WDATA_in, MEM_RDATA, MEM_ACK,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, HOLD, WB_EN, WB_SEL, WB_TYPE, WB_DATA, ERR
  );

  // Environment side: pipeline stage plus data memory.
  modport slave (
    output MR_IN, MW_IN, SelC_in, Type_in, ADDR_in, WDATA_in, MEM_RDATA, MEM_ACK,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, HOLD, WB_EN, WB_SEL, WB_TYPE, WB_DATA, ERR
  );
endinterface

// File: rtl/uc_mem_responder.sv
// Memory-side responder: runs a req/ack access per MR/MW request, stalls the pipeline via HOLD
// and issues a one-cycle register writeback when a load completes.
module uc_mem_responder #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int NOP_SEL = 35
) (
  input logic CK3,
  input logic RST,
  uc_mem_responder_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [5:0] NOP = 6'(NOP_SEL);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mem_req, mem_req_nxt;
  logic          mem_we, mem_we_nxt;
  logic          hold, hold_nxt;
  logic          wb_en, wb_en_nxt;
  logic          err, err_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic [DW-1:0] wb_data, wb_data_nxt;
  logic [5:0]    sel_q, sel_nxt;
  logic [5:0]    wb_sel, wb_sel_nxt;
  logic [6:0]    type_q, type_nxt;
  logic [6:0]    wb_type, wb_type_nxt;
  logic          start;

  assign start = bus.MR_IN | bus.MW_IN;

  always_ff @(posedge CK3 or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      hold    <= 1'b1;
      wb_en   <= 1'b0;
      err     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_data <= '0;
      sel_q   <= NOP;
      wb_sel  <= NOP;
      type_q  <= '0;
      wb_type <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_req <= mem_req_nxt;
      mem_we  <= mem_we_nxt;
      hold    <= hold_nxt;
      wb_en   <= wb_en_nxt;
      err     <= err_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      wb_data <= wb_data_nxt;
      sel_q   <= sel_nxt;
      wb_sel  <= wb_sel_nxt;
      type_q  <= type_nxt;
      wb_type <= wb_type_nxt;
    end
  end

  // Writeback strobe/select are only ever set on the REQ->WB transition, so they last one cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mem_req_nxt = mem_req;
    mem_we_nxt  = mem_we;
    hold_nxt    = hold;
    wb_en_nxt   = 1'b0;
    err_nxt     = err;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    wb_data_nxt = wb_data;
    sel_nxt     = sel_q;
    wb_sel_nxt  = NOP;
    type_nxt    = type_q;
    wb_type_nxt = wb_type;
    case (state)
      IDLE, WB: begin
        if (start) begin
          addr_nxt    = bus.ADDR_in;
          wdata_nxt   = bus.WDATA_in;
          sel_nxt     = bus.SelC_in;
          type_nxt    = bus.Type_in;
          mem_req_nxt = 1'b1;
          mem_we_nxt  = bus.MW_IN;
          hold_nxt    = 1'b0;
          cnt_nxt     = '0;
          err_nxt     = err | (bus.MR_IN & bus.MW_IN);
          state_nxt   = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.MEM_ACK) begin
          mem_req_nxt = 1'b0;
          hold_nxt    = 1'b1;
          if (mem_we) begin
            state_nxt = IDLE;
          end else begin
            wb_data_nxt = bus.MEM_RDATA;
            wb_en_nxt   = (sel_q != NOP);
            wb_sel_nxt  = sel_q;
            wb_type_nxt = type_q;
            state_nxt   = WB;
          end
        end else if (cnt == LAST) begin
          mem_req_nxt = 1'b0;
          err_nxt     = 1'b1;
          hold_nxt    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.MEM_REQ   = mem_req;
  assign bus.MEM_WE    = mem_we;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.HOLD      = hold;
  assign bus.WB_EN     = wb_en;
  assign bus.WB_SEL    = wb_sel;
  assign bus.WB_TYPE   = wb_type;
  assign bus.WB_DATA   = wb_data;
  assign bus.ERR       = err;
endmodule

// File: tb/tb_uc_mem_responder.sv
// Randomized self-checking bench for uc_mem_responder; expectations come from a per-access
// model of stall length, write cycles, writeback timing and the sticky error flag.
module tb_uc_mem_responder;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int T   = 15;
  localparam int NOP = 35;
  localparam int WIN = T + 6;

  logic CK3 = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;
  logic model_err;

  int            obs_req, obs_hold, obs_we, obs_wb, obs_wb_at;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_wb_data;
  logic [5:0]    obs_wb_sel;
  logic [6:0]    obs_wb_type;

  uc_mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  uc_mem_responder #(.AW(AW), .DW(DW), .TIMEOUT(T), .NOP_SEL(NOP)) dut (
    .CK3(CK3),
    .RST(RST),
    .bus(bus)
  );

  always #5 CK3 = ~CK3;

  // Expected outcome of one access whose ack arrives in REQ cycle d (d outside 1..T: never in time).
  task automatic model_access(input logic mr, input logic mw, input logic [5:0] sel, input int d,
                              output int e_stall, output int e_we, output int e_wb, output int e_wb_at);
    bit timeout;
    timeout = (d < 1) || (d > T);
    e_stall = timeout ? T : d;
    e_we    = mw ? e_stall : 0;
    e_wb    = (!mw && !timeout && sel != 6'(NOP)) ? 1 : 0;
    e_wb_at = e_stall + 1;
    if ((mr && mw) || timeout) model_err = 1'b1;
  endtask

  // Issues one request, acks it in REQ cycle d and records what the DUT showed over a fixed window.
  task automatic do_access(input logic mr, input logic mw, input logic [5:0] sel, input logic [6:0] typ,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int d);
    @(negedge CK3);
    bus.MR_IN = mr; bus.MW_IN = mw; bus.SelC_in = sel; bus.Type_in = typ;
    bus.ADDR_in = addr; bus.WDATA_in = wdata;
    @(negedge CK3);
    bus.MR_IN = 1'b0; bus.MW_IN = 1'b0;
    bus.ADDR_in = AW'($urandom); bus.WDATA_in = $urandom;
    obs_req = 0; obs_hold = 0; obs_we = 0; obs_wb = 0; obs_wb_at = 0;
    obs_addr = bus.MEM_ADDR; obs_wdata = bus.MEM_WDATA;
    obs_wb_sel = '0; obs_wb_type = '0; obs_wb_data = '0;
    for (int k = 1; k <= WIN; k++) begin
      if (bus.MEM_REQ) obs_req++;
      if (!bus.HOLD) obs_hold++;
      if (bus.MEM_REQ && bus.MEM_WE) obs_we++;
      if (bus.WB_EN) begin
        obs_wb++; obs_wb_at = k;
        obs_wb_sel = bus.WB_SEL; obs_wb_type = bus.WB_TYPE; obs_wb_data = bus.WB_DATA;
      end
      bus.MEM_ACK = (k == d);
      bus.MEM_RDATA = (k == d) ? rdata : $urandom;
      @(negedge CK3);
      bus.MEM_ACK = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.MR_IN = 0; bus.MW_IN = 0; bus.SelC_in = 0; bus.Type_in = 0;
    bus.ADDR_in = 0; bus.WDATA_in = 0; bus.MEM_RDATA = 0; bus.MEM_ACK = 0;
    model_err = 1'b0;
    #12;
    checks++;
    if ({bus.MEM_REQ, bus.HOLD, bus.MEM_WE, bus.WB_EN, bus.ERR} !== 5'b01000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got REQ,HOLD,WE,WB_EN,ERR=%b expected 01000",
               {bus.MEM_REQ, bus.HOLD, bus.MEM_WE, bus.WB_EN, bus.ERR});
    end
    checks++;
    if (bus.MEM_ADDR !== '0 || bus.MEM_WDATA !== '0 || bus.WB_DATA !== '0 || bus.WB_TYPE !== '0) begin
      failures++;
      $display("[TB] FAIL reset_buses: got addr=%h wdata=%h wb_data=%h wb_type=%h expected all zero",
               bus.MEM_ADDR, bus.MEM_WDATA, bus.WB_DATA, bus.WB_TYPE);
    end
    checks++;
    if (bus.WB_SEL !== 6'(NOP)) begin
      failures++;
      $display("[TB] FAIL reset_wb_sel: got %0d expected %0d", bus.WB_SEL, NOP);
    end
    @(negedge CK3);
    RST = 1'b0;
  endtask

  task automatic test_read();
    int es, ew, eb, ea;
    model_access(1'b1, 1'b0, 6'd5, 1, es, ew, eb, ea);
    do_access(1'b1, 1'b0, 6'd5, 7'h11, 16'h0040, 32'h0, 32'hDEADBEEF, 1);
    checks++;
    if (obs_hold !== es || obs_req !== es) begin
      failures++;
      $display("[TB] FAIL read_stall: got hold_low=%0d req=%0d expected %0d", obs_hold, obs_req, es);
    end
    checks++;
    if (obs_wb !== eb || obs_wb_at !== ea) begin
      failures++;
      $display("[TB] FAIL read_wb_timing: got pulses=%0d at=%0d expected %0d at %0d", obs_wb, obs_wb_at, eb, ea);
    end
    checks++;
    if (obs_wb_sel !== 6'd5 || obs_wb_data !== 32'hDEADBEEF || obs_wb_type !== 7'h11) begin
      failures++;
      $display("[TB] FAIL read_wb_data: got sel=%0d data=%h type=%h expected 5 deadbeef 11",
               obs_wb_sel, obs_wb_data, obs_wb_type);
    end
    checks++;
    if (obs_addr !== 16'h0040 || bus.ERR !== model_err) begin
      failures++;
      $display("[TB] FAIL read_addr_err: got addr=%h err=%b expected 0040 %b", obs_addr, bus.ERR, model_err);
    end
  endtask

  task automatic test_write();
    int es, ew, eb, ea;
    model_access(1'b0, 1'b1, 6'd9, 3, es, ew, eb, ea);
    do_access(1'b0, 1'b1, 6'd9, 7'h22, 16'h0010, 32'h12345678, 32'hCAFEF00D, 3);
    checks++;
    if (obs_we !== ew || obs_hold !== es) begin
      failures++;
      $display("[TB] FAIL write_cycles: got we=%0d hold_low=%0d expected %0d %0d", obs_we, obs_hold, ew, es);
    end
    checks++;
    if (obs_wb !== eb) begin
      failures++;
      $display("[TB] FAIL write_no_wb: got %0d pulses expected %0d", obs_wb, eb);
    end
    checks++;
    if (obs_addr !== 16'h0010 || obs_wdata !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL write_bus: got addr=%h wdata=%h expected 0010 12345678", obs_addr, obs_wdata);
    end
  endtask

  task automatic test_nop_sel();
    int es, ew, eb, ea;
    model_access(1'b1, 1'b0, 6'(NOP), 2, es, ew, eb, ea);
    do_access(1'b1, 1'b0, 6'(NOP), 7'h05, 16'h0200, 32'h0, 32'h0BADF00D, 2);
    checks++;
    if (obs_wb !== eb || obs_hold !== es) begin
      failures++;
      $display("[TB] FAIL nop_sel: got pulses=%0d hold_low=%0d expected %0d %0d", obs_wb, obs_hold, eb, es);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2;
    logic [AW-1:0] a2;
    d1 = $urandom; d2 = $urandom; a2 = AW'($urandom);
    @(negedge CK3);
    bus.MR_IN = 1'b1; bus.SelC_in = 6'd3; bus.Type_in = 7'h21; bus.ADDR_in = 16'h0100;
    @(negedge CK3);
    bus.MR_IN = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = d1;
    @(negedge CK3);
    bus.MEM_ACK = 1'b0;
    checks++;
    if (bus.WB_EN !== 1'b1 || bus.WB_DATA !== d1) begin
      failures++;
      $display("[TB] FAIL b2b_first_wb: got en=%b data=%h expected 1 %h", bus.WB_EN, bus.WB_DATA, d1);
    end
    bus.MR_IN = 1'b1; bus.SelC_in = 6'd7; bus.ADDR_in = a2;
    @(negedge CK3);
    bus.MR_IN = 1'b0;
    checks++;
    if (bus.MEM_REQ !== 1'b1 || bus.MEM_ADDR !== a2 || bus.HOLD !== 1'b0 || bus.WB_EN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second_req: got req=%b addr=%h hold=%b en=%b expected 1 %h 0 0",
               bus.MEM_REQ, bus.MEM_ADDR, bus.HOLD, bus.WB_EN, a2);
    end
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = d2;
    @(negedge CK3);
    bus.MEM_ACK = 1'b0;
    checks++;
    if (bus.WB_EN !== 1'b1 || bus.WB_SEL !== 6'd7 || bus.WB_DATA !== d2) begin
      failures++;
      $display("[TB] FAIL b2b_second_wb: got en=%b sel=%0d data=%h expected 1 7 %h",
               bus.WB_EN, bus.WB_SEL, bus.WB_DATA, d2);
    end
    @(negedge CK3);
    checks++;
    if (bus.WB_EN !== 1'b0 || bus.WB_SEL !== 6'(NOP)) begin
      failures++;
      $display("[TB] FAIL b2b_wb_single: got en=%b sel=%0d expected 0 %0d", bus.WB_EN, bus.WB_SEL, NOP);
    end
  endtask

  task automatic test_timeout();
    int es, ew, eb, ea;
    model_access(1'b1, 1'b0, 6'd12, 0, es, ew, eb, ea);
    do_access(1'b1, 1'b0, 6'd12, 7'h33, 16'h0300, 32'h0, 32'h0, 0);
    checks++;
    if (obs_req !== es || obs_hold !== es) begin
      failures++;
      $display("[TB] FAIL timeout_len: got req=%0d hold_low=%0d expected %0d", obs_req, obs_hold, es);
    end
    checks++;
    if (obs_wb !== eb || bus.ERR !== model_err || bus.HOLD !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_end: got wb=%0d err=%b hold=%b expected %0d %b 1",
               obs_wb, bus.ERR, bus.HOLD, eb, model_err);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge CK3);
    bus.MR_IN = 1'b1; bus.SelC_in = 6'd4; bus.ADDR_in = 16'h0ABC;
    @(negedge CK3);
    bus.MR_IN = 1'b0;
    checks++;
    if (bus.MEM_REQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_pre: got req=%b expected 1", bus.MEM_REQ);
    end
    #2 RST = 1'b1;
    #1;
    model_err = 1'b0;
    checks++;
    if (bus.MEM_REQ !== 1'b0 || bus.HOLD !== 1'b1 || bus.ERR !== model_err || bus.MEM_ADDR !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_now: got req=%b hold=%b err=%b addr=%h expected 0 1 0 0000",
               bus.MEM_REQ, bus.HOLD, bus.ERR, bus.MEM_ADDR);
    end
    @(negedge CK3);
    RST = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h55AA55AA;
    @(negedge CK3);
    bus.MEM_ACK = 1'b0;
    @(negedge CK3);
    checks++;
    if (bus.WB_EN !== 1'b0 || bus.MEM_REQ !== 1'b0 || bus.ERR !== model_err) begin
      failures++;
      $display("[TB] FAIL midreset_discard: got en=%b req=%b err=%b expected 0 0 %b",
               bus.WB_EN, bus.MEM_REQ, bus.ERR, model_err);
    end
  endtask

  task automatic test_both();
    int es, ew, eb, ea;
    model_access(1'b1, 1'b1, 6'd8, 2, es, ew, eb, ea);
    do_access(1'b1, 1'b1, 6'd8, 7'h44, 16'h0400, 32'hA5A5A5A5, 32'h0, 2);
    checks++;
    if (obs_we !== ew || obs_wb !== eb || obs_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("[TB] FAIL both_write_only: got we=%0d wb=%0d wdata=%h expected %0d %0d a5a5a5a5",
               obs_we, obs_wb, obs_wdata, ew, eb);
    end
    checks++;
    if (bus.ERR !== model_err) begin
      failures++;
      $display("[TB] FAIL both_err: got %b expected %b", bus.ERR, model_err);
    end
  endtask

  task automatic test_random();
    int es, ew, eb, ea, d, kind;
    logic mr, mw;
    logic [5:0] sel;
    logic [6:0] typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      mr = (kind == 0) || (kind > 4);
      mw = (kind <= 4);
      sel = ($urandom_range(0, 7) == 0) ? 6'(NOP) : 6'($urandom_range(0, 63));
      typ = 7'($urandom); addr = AW'($urandom); wdata = $urandom; rdata = $urandom;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 3) : $urandom_range(1, 4);
      model_access(mr, mw, sel, d, es, ew, eb, ea);
      do_access(mr, mw, sel, typ, addr, wdata, rdata, d);
      checks++;
      if (obs_req !== es || obs_hold !== es || obs_we !== ew) begin
        failures++;
        $display("[TB] FAIL rand%0d_cycles: got req=%0d hold_low=%0d we=%0d expected %0d %0d %0d",
                 i, obs_req, obs_hold, obs_we, es, es, ew);
      end
      checks++;
      if (obs_addr !== addr || obs_wdata !== wdata) begin
        failures++;
        $display("[TB] FAIL rand%0d_bus: got addr=%h wdata=%h expected %h %h", i, obs_addr, obs_wdata, addr, wdata);
      end
      checks++;
      if (obs_wb !== eb || (eb == 1 && (obs_wb_at !== ea || obs_wb_sel !== sel ||
          obs_wb_type !== typ || obs_wb_data !== rdata))) begin
        failures++;
        $display("[TB] FAIL rand%0d_wb: got n=%0d at=%0d sel=%0d type=%h data=%h expected n=%0d at=%0d sel=%0d type=%h data=%h",
                 i, obs_wb, obs_wb_at, obs_wb_sel, obs_wb_type, obs_wb_data, eb, ea, sel, typ, rdata);
      end
      checks++;
      if (bus.ERR !== model_err) begin
        failures++;
        $display("[TB] FAIL rand%0d_err: got %b expected %b", i, bus.ERR, model_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nop_sel();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    test_both();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a stalled run; the normal sequence ends long before this.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
